// File: rtl/mem_slice_pkg.sv
// rtl/mem_slice_pkg.sv - shared state encoding and configuration constants for mem_slice
package mem_slice_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    localparam int unsigned TIMEOUT_DEFAULT = 255;
    localparam int unsigned TIMER_W         = 16;

endpackage

// File: rtl/mem_slice_timer.sv
// rtl/mem_slice_timer.sv - wait-state cycle counter; expired flags the TIMEOUT-th enabled cycle
module mem_slice_timer
    import mem_slice_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [TIMER_W-1:0] LAST = TIMER_W'(TIMEOUT - 1);

    logic [TIMER_W-1:0] count;

    // The count equals the number of completed wait cycles, so the TIMEOUT-th one is count == TIMEOUT-1
    assign expired = enable && (count == LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mem_slice.sv
// rtl/mem_slice.sv - single-outstanding request slice, arbiter to slave decode (timeout option: MEM_SLICE_TIMEOUT_EN)
module mem_slice
    import mem_slice_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        reset,
    input  logic        clock,
    input  logic        memory_valid,
    input  logic        memory_instr,
    input  logic [31:0] memory_addr,
    input  logic [31:0] memory_wdata,
    input  logic [3:0]  memory_wstrb,
    output logic [31:0] memory_rdata,
    output logic        memory_error,
    output logic        memory_ready,
    output logic        slave_valid,
    output logic        slave_instr,
    output logic [31:0] slave_addr,
    output logic [31:0] slave_wdata,
    output logic [3:0]  slave_wstrb,
    input  logic [31:0] slave_rdata,
    input  logic        slave_error,
    input  logic        slave_ready,
    output logic        slice_busy,
    output logic        slice_drop
);

    state_t state;
    logic   timeout_hit;

    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_timeout_out_of_range
    end

`ifdef MEM_SLICE_TIMEOUT_EN
    logic timer_expired;

    mem_slice_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clock   (clock),
        .reset   (reset),
        .clear   (state == ST_REQ),
        .enable  (state == ST_WAIT),
        .expired (timer_expired)
    );

    assign timeout_hit = timer_expired;
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            memory_rdata <= '0;
            memory_error <= 1'b0;
            memory_ready <= 1'b0;
            slave_valid  <= 1'b0;
            slave_instr  <= 1'b0;
            slave_addr   <= '0;
            slave_wdata  <= '0;
            slave_wstrb  <= '0;
            slice_busy   <= 1'b0;
            slice_drop   <= 1'b0;
        end else begin
            // Response and request strobes are single-cycle; only the entering transition raises them
            memory_ready <= 1'b0;
            memory_rdata <= '0;
            memory_error <= 1'b0;
            slave_valid  <= 1'b0;

            if (memory_valid && slice_busy) begin
                slice_drop <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (memory_valid) begin
                        slave_instr <= memory_instr;
                        slave_addr  <= memory_addr;
                        slave_wdata <= memory_wdata;
                        slave_wstrb <= memory_wstrb;
                        slave_valid <= 1'b1;
                        slice_busy  <= 1'b1;
                        state       <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (slave_ready) begin
                        memory_ready <= 1'b1;
                        memory_rdata <= slave_rdata;
                        memory_error <= slave_error;
                        state        <= ST_RESP;
                    end else begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // A real response in the expiry cycle takes priority over the timeout error
                    if (slave_ready) begin
                        memory_ready <= 1'b1;
                        memory_rdata <= slave_rdata;
                        memory_error <= slave_error;
                        state        <= ST_RESP;
                    end else if (timeout_hit) begin
                        memory_ready <= 1'b1;
                        memory_error <= 1'b1;
                        state        <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    slice_busy <= 1'b0;
                    state      <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_slice.sv
// tb/tb_mem_slice.sv - scoreboard bench for mem_slice (timeout cases need MEM_SLICE_TIMEOUT_EN)
module tb_mem_slice;

    localparam int TMO_P = 4;
`ifdef MEM_SLICE_TIMEOUT_EN
    localparam int TMO = TMO_P;
`else
    localparam int TMO = 100000;
`endif

    typedef struct {
        int          cyc;
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    typedef struct {
        int          cyc;
        logic [31:0] rdata;
        logic        error;
    } rsp_t;

    logic        reset = 1'b0;
    logic        clock = 1'b0;
    logic        memory_valid = 1'b0;
    logic        memory_instr = 1'b0;
    logic [31:0] memory_addr = '0;
    logic [31:0] memory_wdata = '0;
    logic [3:0]  memory_wstrb = '0;
    logic [31:0] memory_rdata;
    logic        memory_error;
    logic        memory_ready;
    logic        slave_valid;
    logic        slave_instr;
    logic [31:0] slave_addr;
    logic [31:0] slave_wdata;
    logic [3:0]  slave_wstrb;
    logic [31:0] slave_rdata = '0;
    logic        slave_error = 1'b0;
    logic        slave_ready = 1'b0;
    logic        slice_busy;
    logic        slice_drop;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    bit   drop_exp = 1'b0;
    req_t req_q[$];
    rsp_t rsp_q[$];

    mem_slice #(
        .TIMEOUT (TMO_P)
    ) dut (
        .reset        (reset),
        .clock        (clock),
        .memory_valid (memory_valid),
        .memory_instr (memory_instr),
        .memory_addr  (memory_addr),
        .memory_wdata (memory_wdata),
        .memory_wstrb (memory_wstrb),
        .memory_rdata (memory_rdata),
        .memory_error (memory_error),
        .memory_ready (memory_ready),
        .slave_valid  (slave_valid),
        .slave_instr  (slave_instr),
        .slave_addr   (slave_addr),
        .slave_wdata  (slave_wdata),
        .slave_wstrb  (slave_wstrb),
        .slave_rdata  (slave_rdata),
        .slave_error  (slave_error),
        .slave_ready  (slave_ready),
        .slice_busy   (slice_busy),
        .slice_drop   (slice_drop)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: pops the scoreboard whenever the DUT presents a request or a response
    always @(negedge clock) begin
        if (reset) begin
            if (slave_valid) begin
                if (req_q.size() == 0) begin
                    check("unexpected_slave_valid", 64'd1, 64'd0);
                end else begin
                    req_t e;
                    e = req_q.pop_front();
                    check("slave_valid_cycle", 64'(cyc), 64'(e.cyc));
                    check("slave_fields", {slave_instr, slave_addr, slave_wdata, slave_wstrb},
                          {e.instr, e.addr, e.wdata, e.wstrb});
                end
            end
            if (memory_ready) begin
                if (rsp_q.size() == 0) begin
                    check("unexpected_memory_ready", 64'd1, 64'd0);
                end else begin
                    rsp_t e;
                    e = rsp_q.pop_front();
                    check("memory_ready_cycle", 64'(cyc), 64'(e.cyc));
                    check("memory_response", {memory_error, memory_rdata}, {e.error, e.rdata});
                end
            end else begin
                check("memory_rdata_idle_zero", 64'(memory_rdata), 64'd0);
            end
        end
    end

    task automatic do_txn(input logic instr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input int d, input logic [31:0] rd,
                          input logic er, input bit collide);
        req_t rq;
        rsp_t rs;
        int   q;
        int   n;
        memory_valid = 1'b1;
        memory_instr = instr;
        memory_addr  = addr;
        memory_wdata = wdata;
        memory_wstrb = wstrb;
        rq.cyc = cyc + 1; rq.instr = instr; rq.addr = addr; rq.wdata = wdata; rq.wstrb = wstrb;
        req_q.push_back(rq);
        @(negedge clock);
        q = cyc;
        memory_valid = 1'b0;
        memory_instr = ~instr;
        memory_addr  = $urandom;
        memory_wdata = $urandom;
        memory_wstrb = 4'($urandom);
        check("busy_in_req", 64'(slice_busy), 64'd1);
        if (d > TMO) begin
            rs.cyc = q + TMO + 1; rs.rdata = '0; rs.error = 1'b1;
            rsp_q.push_back(rs);
        end
        if (collide) begin
            memory_valid = 1'b1;
            memory_addr  = 32'h0000_0200;
            drop_exp     = 1'b1;
        end
        for (int i = 0; i < d; i++) begin
            @(negedge clock);
            memory_valid = 1'b0;
        end
        slave_ready = 1'b1;
        slave_rdata = rd;
        slave_error = er;
        if (d <= TMO) begin
            rs.cyc = cyc + 1; rs.rdata = rd; rs.error = er;
            rsp_q.push_back(rs);
        end
        @(negedge clock);
        memory_valid = 1'b0;
        slave_ready  = 1'b0;
        slave_rdata  = $urandom;
        slave_error  = 1'($urandom);
        n = 0;
        while (slice_busy && n < 20) begin
            @(negedge clock);
            n++;
        end
        check("busy_released", 64'(slice_busy), 64'd0);
        check("slave_hold", {slave_instr, slave_addr, slave_wdata, slave_wstrb}, {instr, addr, wdata, wstrb});
        check("slice_drop", 64'(slice_drop), 64'(drop_exp));
        @(negedge clock);
    endtask

    initial begin
        @(negedge clock);
        check("reset_outputs", {memory_rdata, memory_error, memory_ready, slave_valid, slave_instr,
                                slave_wstrb, slice_busy, slice_drop}, '0);
        check("reset_slave_regs", {slave_addr, slave_wdata}, '0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        do_txn(1'b0, 32'h0000_0100, 32'h0, 4'h0, 2, 32'hDEAD_BEEF, 1'b0, 1'b0);
        do_txn(1'b0, 32'h8000_0004, 32'h1234_5678, 4'hF, 3, 32'h0, 1'b0, 1'b0);
        do_txn(1'b1, 32'h0000_0040, 32'h0, 4'h0, 0, 32'hCAFE_F00D, 1'b1, 1'b0);
        do_txn(1'b0, 32'h0000_0100, 32'h0, 4'h0, 2, 32'h1111_2222, 1'b0, 1'b1);
`ifdef MEM_SLICE_TIMEOUT_EN
        do_txn(1'b0, 32'h0000_0300, 32'h0, 4'h0, TMO, 32'h3333_4444, 1'b0, 1'b0);
        do_txn(1'b0, 32'h0000_0304, 32'h0, 4'h0, TMO + 2, 32'h5555_6666, 1'b0, 1'b0);
`endif
        for (int k = 0; k < 40; k++) begin
            do_txn(1'($urandom), $urandom, $urandom, 4'($urandom), int'($urandom_range(0, 7)),
                   $urandom, 1'($urandom_range(0, 3) == 0), $urandom_range(0, 4) == 0);
        end

        // Reset in the middle of a wait: nothing may be answered afterwards
        memory_valid = 1'b1;
        memory_instr = 1'b1;
        memory_addr  = 32'h0000_0500;
        memory_wdata = 32'hA5A5_A5A5;
        memory_wstrb = 4'h3;
        begin
            req_t rq;
            rq.cyc = cyc + 1; rq.instr = 1'b1; rq.addr = 32'h0000_0500;
            rq.wdata = 32'hA5A5_A5A5; rq.wstrb = 4'h3;
            req_q.push_back(rq);
        end
        @(negedge clock);
        memory_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        drop_exp = 1'b0;
        #1;
        check("midreset_outputs", {memory_rdata, memory_error, memory_ready, slave_valid, slave_instr,
                                   slave_wstrb, slice_busy, slice_drop}, '0);
        check("midreset_slave_regs", {slave_addr, slave_wdata}, '0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        slave_ready = 1'b1;
        slave_rdata = 32'hBAD0_BAD0;
        @(negedge clock);
        slave_ready = 1'b0;
        repeat (4) @(negedge clock);
        check("post_reset_idle", {slice_busy, slice_drop}, '0);

        check("req_queue_drained", 64'(req_q.size()), 64'd0);
        check("rsp_queue_drained", 64'(rsp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
